// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types, bus widths and slot decode for apb_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam int SLOT_LSB  = 24;
    localparam int SLOT_BITS = 4;
    localparam int NUM_SLOTS = 1 << SLOT_BITS;
    localparam int APB_DW    = 32;
    localparam int APB_AW    = 32;

    // One-hot PSEL vector for the peripheral slot carried in PADDR[27:24].
    function automatic logic [NUM_SLOTS-1:0] slot_decode(input logic [SLOT_BITS-1:0] slot);
        logic [NUM_SLOTS-1:0] onehot;
        onehot       = '0;
        onehot[slot] = 1'b1;
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches upward from
//               i_last+1 with wrap, skipping masked requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [IW-1:0]   i_last,
    output logic            o_valid,
    output logic [IW-1:0]   o_winner
);

    logic [NREQ-1:0] w_elig;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic [IW-1:0]   w_sel;

    assign w_elig = i_req & ~i_mask;

    // Offset 1 is the highest priority, offset NREQ (last owner itself) lowest.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign o_valid  = w_found;
    assign o_winner = w_sel;

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin sharing of one APB3 master port among NREQ local
//               requesters, with wait states, PSLVERR capture and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ-1:0]        REQ_WRITE,
    input  logic [APB_AW*NREQ-1:0] REQ_ADDR,
    input  logic [APB_DW*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]        GNT,
    output logic [NREQ-1:0]        ACK,
    output logic [APB_DW-1:0]      RDATA,
    output logic                   ERR,
    output logic                   BUSY,
    output logic [APB_AW-1:0]      PADDR,
    output logic                   PWRITE,
    output logic [APB_DW-1:0]      PWDATA,
    output logic [NUM_SLOTS-1:0]   PSEL,
    output logic                   PENABLE,
    input  logic [APB_DW-1:0]      PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int                 c_IW      = $clog2(NREQ);
    localparam int                 c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO     = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    arb_state_e           r_state,   w_state_nxt;
    logic [NREQ-1:0]      r_gnt,     w_gnt_nxt;
    logic [NREQ-1:0]      r_ack,     w_ack_nxt;
    logic [APB_DW-1:0]    r_rdata,   w_rdata_nxt;
    logic                 r_err,     w_err_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic [APB_AW-1:0]    r_paddr,   w_paddr_nxt;
    logic                 r_pwrite,  w_pwrite_nxt;
    logic [APB_DW-1:0]    r_pwdata,  w_pwdata_nxt;
    logic [NUM_SLOTS-1:0] r_psel,    w_psel_nxt;
    logic                 r_penable, w_penable_nxt;
    logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [c_IW-1:0]      r_last,    w_last_nxt;
    logic [c_IW-1:0]      r_owner,   w_owner_nxt;

    logic [APB_AW-1:0]    w_req_addr  [NREQ];
    logic [APB_DW-1:0]    w_req_wdata [NREQ];
    logic                 w_pick_valid;
    logic [c_IW-1:0]      w_winner;
    logic [APB_AW-1:0]    w_win_addr;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_addr[gi]  = REQ_ADDR[gi*APB_AW +: APB_AW];
            assign w_req_wdata[gi] = REQ_WDATA[gi*APB_DW +: APB_DW];
        end
    endgenerate

    // The requester acked this cycle is masked so it cannot immediately re-win.
    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_rr_pick (
        .i_req    (REQ),
        .i_mask   (r_ack),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_winner)
    );

    assign w_win_addr = w_req_addr[w_winner];
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_TMO);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_last    <= c_IW'(NREQ - 1);
            r_owner   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ack     <= w_ack_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
        end
    end

    // Next values for every registered output; ACK/ERR/RDATA default to a
    // single-cycle pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_ack_nxt     = '0;
        w_rdata_nxt   = '0;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = r_busy;
        w_paddr_nxt   = r_paddr;
        w_pwrite_nxt  = r_pwrite;
        w_pwdata_nxt  = r_pwdata;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;

        case (r_state)
            IDLE: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (w_pick_valid) begin
                    w_state_nxt          = SETUP;
                    w_gnt_nxt            = '0;
                    w_gnt_nxt[w_winner]  = 1'b1;
                    w_owner_nxt          = w_winner;
                    w_paddr_nxt          = w_win_addr;
                    w_pwrite_nxt         = REQ_WRITE[w_winner];
                    w_pwdata_nxt         = w_req_wdata[w_winner];
                    w_psel_nxt           = slot_decode(w_win_addr[SLOT_LSB +: SLOT_BITS]);
                    w_busy_nxt           = 1'b1;
                    w_cnt_nxt            = '0;
                end
            end

            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = w_cnt_inc;
            end

            ACCESS: begin
                w_cnt_nxt = w_cnt_inc;
                if (PREADY || w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_gnt_nxt     = '0;
                    w_ack_nxt     = r_gnt;
                    w_last_nxt    = r_owner;
                    w_err_nxt     = PREADY ? PSLVERR : 1'b1;
                    if (PREADY && !PSLVERR && !r_pwrite) begin
                        w_rdata_nxt = PRDATA;
                    end
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_gnt_nxt     = '0;
            end
        endcase
    end

    assign GNT     = r_gnt;
    assign ACK     = r_ack;
    assign RDATA   = r_rdata;
    assign ERR     = r_err;
    assign BUSY    = r_busy;
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Scoreboard bench for apb_req_arbiter (NREQ=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic         PCLK    = 1'b0;
    logic         PRESET  = 1'b0;
    logic [3:0]   REQ     = '0;
    logic [3:0]   REQ_WRITE = '0;
    logic [31:0]  a [4];
    logic [31:0]  d [4];
    logic [127:0] REQ_ADDR;
    logic [127:0] REQ_WDATA;
    logic [3:0]   GNT, ACK;
    logic [31:0]  RDATA;
    logic         ERR, BUSY;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [15:0]  PSEL;
    logic         PENABLE;
    logic [31:0]  PRDATA  = '0;
    logic         PREADY  = 1'b1;
    logic         PSLVERR = 1'b0;

    assign REQ_ADDR  = {a[3], a[2], a[1], a[0]};
    assign REQ_WDATA = {d[3], d[2], d[1], d[0]};

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ       (REQ),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .ACK       (ACK),
        .RDATA     (RDATA),
        .ERR       (ERR),
        .BUSY      (BUSY),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        int          cyc;
    } setup_t;

    typedef struct {
        logic [3:0]  ack;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    setup_t      sq[$];
    ack_t        aq[$];
    setup_t      se;
    ack_t        ae;
    logic [15:0] cur_psel  = '0;
    logic [31:0] cur_paddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_setup(input int r, input logic [15:0] psel, input int c);
        setup_t s;
        s.gnt    = 4'b0001 << r;
        s.psel   = psel;
        s.paddr  = a[r];
        s.pwrite = REQ_WRITE[r];
        s.pwdata = d[r];
        s.cyc    = c;
        sq.push_back(s);
    endtask

    task automatic push_ack(input int r, input logic err, input logic [31:0] rd, input int c);
        ack_t s;
        s.ack   = 4'b0001 << r;
        s.err   = err;
        s.rdata = rd;
        s.cyc   = c;
        aq.push_back(s);
    endtask

    // Returns at the negedge where ACK[r] is seen, or after a bounded wait.
    task automatic wait_ack(input int r);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge PCLK);
            if (ACK[r]) seen = 1'b1;
        end
        chk($sformatf("ack_seen_r%0d", r), 64'(seen), 64'(1));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents SETUP or ACK.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL != 16'h0 && !PENABLE) begin
                if (sq.size() == 0) begin
                    chk("unexpected_setup", 64'(PSEL), 64'(0));
                end else begin
                    se = sq.pop_front();
                    chk("setup_gnt",    64'(GNT),    64'(se.gnt));
                    chk("setup_psel",   64'(PSEL),   64'(se.psel));
                    chk("setup_paddr",  64'(PADDR),  64'(se.paddr));
                    chk("setup_pwrite", 64'(PWRITE), 64'(se.pwrite));
                    chk("setup_pwdata", 64'(PWDATA), 64'(se.pwdata));
                    chk("setup_busy",   64'(BUSY),   64'(1));
                    chk("setup_cycle",  64'(cyc),    64'(se.cyc));
                end
                cur_psel  = PSEL;
                cur_paddr = PADDR;
            end
            if (PENABLE) begin
                chk("access_psel",  64'(PSEL),  64'(cur_psel));
                chk("access_paddr", 64'(PADDR), 64'(cur_paddr));
            end
            if (ACK != 4'h0) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", 64'(ACK), 64'(0));
                end else begin
                    ae = aq.pop_front();
                    chk("ack_vec",   64'(ACK),   64'(ae.ack));
                    chk("ack_err",   64'(ERR),   64'(ae.err));
                    chk("ack_rdata", 64'(RDATA), 64'(ae.rdata));
                    chk("ack_cycle", 64'(cyc),   64'(ae.cyc));
                    chk("ack_gnt",   64'(GNT),   64'(0));
                    chk("ack_psel",  64'(PSEL),  64'(0));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    logic [15:0] psel_tab [4];
    int          t0;

    initial begin
        psel_tab = '{16'h0010, 16'h0020, 16'h0040, 16'h0080};
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            d[i] = '0;
        end

        // Reset state
        #2 PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_gnt",     64'(GNT),     64'(0));
        chk("rst_ack",     64'(ACK),     64'(0));
        chk("rst_psel",    64'(PSEL),    64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_busy",    64'(BUSY),    64'(0));
        chk("rst_paddr",   64'(PADDR),   64'(0));
        chk("rst_err",     64'(ERR),     64'(0));
        chk("rst_rdata",   64'(RDATA),   64'(0));
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Contention: all four held, zero wait, grants 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h0400_0000 + (i << 24) + (i * 4);
            d[i] = 32'hA0A0_0000 + i;
        end
        REQ_WRITE = 4'b0101;
        PRDATA    = 32'h1111_2222;
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            push_setup(k % 4, psel_tab[k % 4], t0 + 1 + 3 * k);
            push_ack(k % 4, 1'b0, REQ_WRITE[k % 4] ? 32'h0 : 32'h1111_2222, t0 + 3 + 3 * k);
        end
        REQ = 4'b1111;
        for (int k = 0; k < 6; k++) wait_ack(k % 4);
        REQ = 4'b0000;
        @(posedge PCLK); #1;

        // Single write, PREADY tied high; RDATA must stay 0 for a write
        a[0] = 32'h0300_0010;
        d[0] = 32'hDEAD_BEEF;
        REQ_WRITE[0] = 1'b1;
        PRDATA = 32'h5555_AAAA;
        t0 = cyc;
        push_setup(0, 16'h0008, t0 + 1);
        push_ack(0, 1'b0, 32'h0, t0 + 3);
        REQ[0] = 1'b1;
        wait_ack(0);
        REQ[0] = 1'b0;
        @(posedge PCLK); #1;

        // Read with three wait states
        a[2] = 32'h0A00_0004;
        d[2] = 32'h0000_0077;
        REQ_WRITE[2] = 1'b0;
        PRDATA = 32'h1234_5678;
        PREADY = 1'b0;
        t0 = cyc;
        push_setup(2, 16'h0400, t0 + 1);
        push_ack(2, 1'b0, 32'h1234_5678, t0 + 6);
        REQ[2] = 1'b1;
        wait_until(t0 + 5);
        PREADY = 1'b1;
        wait_ack(2);
        REQ[2] = 1'b0;
        @(posedge PCLK); #1;

        // Slave error on a read
        a[1] = 32'h0500_0000;
        REQ_WRITE[1] = 1'b0;
        PRDATA  = 32'hCAFE_F00D;
        PSLVERR = 1'b1;
        t0 = cyc;
        push_setup(1, 16'h0020, t0 + 1);
        push_ack(1, 1'b1, 32'h0, t0 + 3);
        REQ[1] = 1'b1;
        wait_ack(1);
        REQ[1] = 1'b0;
        PSLVERR = 1'b0;
        @(posedge PCLK); #1;

        // Timeout on requester 3, requester 0 pending behind it
        a[3] = 32'h0F00_0000;
        d[3] = 32'h0000_3333;
        REQ_WRITE[3] = 1'b1;
        a[0] = 32'h0200_0008;
        d[0] = 32'h0BAD_0000;
        REQ_WRITE[0] = 1'b1;
        PREADY = 1'b0;
        t0 = cyc;
        push_setup(3, 16'h8000, t0 + 1);
        push_ack(3, 1'b1, 32'h0, t0 + 10);
        push_setup(0, 16'h0004, t0 + 11);
        push_ack(0, 1'b0, 32'h0, t0 + 13);
        REQ = 4'b1001;
        wait_ack(3);
        chk("tmo_psel_drop",    64'(PSEL),    64'(0));
        chk("tmo_penable_drop", 64'(PENABLE), 64'(0));
        REQ[3] = 1'b0;
        @(posedge PCLK); #1;
        chk("tmo_next_gnt", 64'(GNT), 64'(4'b0001));
        PREADY = 1'b1;
        wait_ack(0);
        REQ[0] = 1'b0;
        @(posedge PCLK); #1;

        // Reset asserted during ACCESS: no ACK, requester 0 wins after release
        a[2] = 32'h0100_0000;
        d[2] = 32'h0000_0066;
        REQ_WRITE[2] = 1'b1;
        PREADY = 1'b0;
        t0 = cyc;
        push_setup(2, 16'h0002, t0 + 1);
        REQ[2] = 1'b1;
        wait_until(t0 + 2);
        chk("pre_rst_penable", 64'(PENABLE), 64'(1));
        PRESET = 1'b1;
        #1;
        chk("mid_rst_psel",    64'(PSEL),    64'(0));
        chk("mid_rst_penable", 64'(PENABLE), 64'(0));
        chk("mid_rst_gnt",     64'(GNT),     64'(0));
        chk("mid_rst_busy",    64'(BUSY),    64'(0));
        chk("mid_rst_ack",     64'(ACK),     64'(0));
        @(posedge PCLK); #1;
        a[0] = 32'h0900_0000;
        REQ_WRITE[0] = 1'b0;
        PRDATA = 32'h0000_0099;
        PREADY = 1'b1;
        REQ[0] = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        t0 = cyc;
        push_setup(0, 16'h0200, t0 + 1);
        push_ack(0, 1'b0, 32'h0000_0099, t0 + 3);
        push_setup(2, 16'h0002, t0 + 4);
        push_ack(2, 1'b0, 32'h0, t0 + 6);
        wait_ack(0);
        REQ[0] = 1'b0;
        wait_ack(2);
        REQ[2] = 1'b0;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("sb_setup_left", 64'(sq.size()), 64'(0));
        chk("sb_ack_left",   64'(aq.size()), 64'(0));
        chk("idle_busy",     64'(BUSY),      64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares one APB3 master port among up to NREQ local requesters: round-robin arbitration, full SETUP/ACCESS sequencing with PREADY wait states, PSLVERR capture and a bounded-wait timeout. Sits between test/controller logic and the 16-slot APB peripheral fabric, in place of a single-master bus driver. It drives the same PSEL[15:0] slot map, with the slot taken from PADDR[27:24].

## Interface
- NREQ, 4: number of requesters, legal 2..4.
- TIMEOUT, 256: maximum ACCESS cycles before abort. 0 disables the timeout.
- PCLK  in  1: the single clock.
- PRESET  in  1: reset, asynchronous, active-high.
- REQ  in  NREQ: per-requester transaction request, level.
- REQ_WRITE  in  NREQ: per-requester direction, 1 = write.
- REQ_ADDR  in  32*NREQ: packed addresses, requester i at [32i+31:32i].
- REQ_WDATA  in  32*NREQ: packed write data.
- GNT  out  NREQ: one-hot, registered. Identifies the current owner from SETUP to completion.
- ACK  out  NREQ: one-cycle completion pulse to the owner.
- RDATA  out  32: read data, valid while ACK is high. 0 for writes and on error.
- ERR  out  1: valid while ACK is high. Set by PSLVERR or by timeout.
- BUSY  out  1: high in SETUP and ACCESS.
- PADDR  out  32, PWRITE  out  1, PWDATA  out  32, PSEL  out  16, PENABLE  out  1: APB3 master outputs.
- PRDATA  in  32, PREADY  in  1, PSLVERR  in  1: APB3 slave responses.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any unmasked REQ is high, pick a winner round-robin, searching from last_grant+1 upward with wrap.
  - Register REQ_ADDR, REQ_WRITE and REQ_WDATA of the winner into PADDR, PWRITE and PWDATA.
  - Set GNT[winner] and go to SETUP.
- **SETUP**
  - PSEL[PADDR[27:24]] = 1, PENABLE = 0.
  - Always moves to ACCESS next cycle.
- **ACCESS**
  - PSEL held, PENABLE = 1, wait counter increments each cycle.
  - On PREADY = 1: capture PRDATA (reads only) and PSLVERR, go to IDLE.
  - On counter == TIMEOUT with PREADY = 0 (TIMEOUT ≠ 0): capture error, go to IDLE.
- **Completion cycle** (first IDLE cycle after ACCESS)
  - ACK[owner] = 1 and GNT cleared.
  - ERR = PSLVERR or timeout. RDATA = PRDATA for a successful read, else 0.
  - last_grant is updated to the owner.
- **Requester rules**
  - Hold address, direction and data stable from REQ rise until ACK.
  - REQ still high after ACK requests a new transaction.
  - The just-acked requester is masked during its ACK cycle. Other requesters may win in that same cycle.
- **Simultaneous requests:** at most one grant per IDLE cycle. Losers wait with REQ held; they are never dropped.
- **REQ dropped before grant:** ignored, no transaction issued. Dropping REQ after grant is illegal; the transaction still completes.
- **Counter width:** clog2(TIMEOUT+1). It saturates and is cleared on entry to SETUP.
- **Reset**
  - On PRESET = 1, at any time including mid-ACCESS, the block immediately goes to IDLE.
  - All outputs are 0 and last_grant = NREQ-1, so requester 0 wins first.
  - No ACK is issued for an aborted transfer.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum transaction (REQ high in cycle 0):
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, PREADY = 1.
  - Cycle 3: ACK.
- Each PREADY-low cycle adds one cycle of latency.
- Back-to-back: the next SETUP can begin in the cycle after ACK, giving 3 cycles per zero-wait transfer.
- Timeout: ACK follows TIMEOUT ACCESS cycles, at cycle TIMEOUT+2.
- PSEL and PADDR are stable from SETUP through the last ACCESS cycle.

## Structure
- Package apb_arb_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS};
  - SLOT_LSB = 24, SLOT_BITS = 4, APB_DW = 32, APB_AW = 32;
  - the 16-bit one-hot slot decode function.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, mask, last index.
  - Outputs: valid, winner index.
- Top level holds the FSM, capture registers and wait counter.

## Test plan
- Single write: REQ[0] with addr 0x0300_0010, data 0xDEAD_BEEF, PREADY tied 1.
  - Expect PSEL = 0x0008, SETUP then ACCESS, ACK[0] at cycle 3, ERR = 0.
- Contention: REQ = 4'b1111 held continuously, zero wait.
  - Expect grants in order 0, 1, 2, 3, 0, 1, one transfer per 3 cycles, no requester starved.
- Wait states and read: REQ[2] reading addr 0x0A00_0004, PREADY low for 3 ACCESS cycles, PRDATA = 0x1234_5678.
  - Expect ACK[2] at cycle 6 with RDATA = 0x1234_5678.
- Slave error: PSLVERR = 1 with PREADY = 1 on a read.
  - Expect ERR = 1 and RDATA = 0 with the ACK.
- Timeout: TIMEOUT = 8, PREADY held 0.
  - Expect PSEL dropped and ACK with ERR = 1 at cycle 10.
  - Expect the next pending requester granted in the following cycle.
- Reset mid-ACCESS: assert PRESET in the ACCESS cycle.
  - Expect PSEL, PENABLE, GNT and BUSY at 0 immediately, no ACK.
  - After release, requester 0 wins first.
